// File: rtl/pe_con_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pe_con_pkg
// Brief    : Shared types and constants for the pe_controller dot-product PE:
//            controller state encoding, DONE window length and result width.
// Revision : 1.0 - initial release
// ============================================================================
package pe_con_pkg;

  // Controller states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } pe_state_t;

  // Number of cycles the done flag stays high after a run
  localparam int DONE_CYCLES = 5;

  // Full-precision dot-product width: one product plus log2(N) growth bits
  function automatic int result_width(input int data_w, input int l_ram_size);
    return 2 * data_w + l_ram_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac
// Brief    : Registered multiply-accumulate. Clear has priority over enable;
//            the accumulator is wide enough that it never overflows.
// Config   : PE_CON_SIGNED_EN - operands are two's complement and the product
//            is sign-extended into the accumulator (default: unsigned).
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic [2*DATA_W-1:0] w_a_ext;
  logic [2*DATA_W-1:0] w_b_ext;
  logic [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    r_acc;

`ifdef PE_CON_SIGNED_EN
  // Sign-extend operands; the low 2*DATA_W bits of the product are then exact
  assign w_a_ext    = {{DATA_W{i_a[DATA_W-1]}}, i_a};
  assign w_b_ext    = {{DATA_W{i_b[DATA_W-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
`else
  assign w_a_ext    = {{DATA_W{1'b0}}, i_a};
  assign w_b_ext    = {{DATA_W{1'b0}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
`endif

  // Accumulate one product per enabled cycle; clear starts a new sum
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/pe_controller.sv
`default_nettype none
// ============================================================================
// Module   : pe_controller
// Brief    : Dot-product processing element. On start, streams A (words
//            0..N-1) and B (words N..2N-1) from a 1-cycle-latency RAM into
//            local register files, accumulates sum(A[i]*B[i]) over N cycles,
//            then presents the result with a 5-cycle done window.
// Config   : PE_CON_SIGNED_EN - signed elements and result (default unsigned);
//            the option lives in pe_mac.
// Revision : 1.0 - initial release
// ============================================================================
module pe_controller
  import pe_con_pkg::*;
#(
  parameter int VECTOR_SIZE = 8,
  parameter int L_RAM_SIZE  = 3,
  parameter int DATA_W      = 8
) (
  input  logic                                         aclk,
  input  logic                                         aresetn,
  input  logic                                         start,
  input  logic [DATA_W-1:0]                            rddata,
  output logic [L_RAM_SIZE:0]                          rdaddr,
  output logic                                         done,
  output logic [result_width(DATA_W, L_RAM_SIZE)-1:0]  result
);

  localparam int c_RES_W  = result_width(DATA_W, L_RAM_SIZE);
  localparam int c_ADDR_W = L_RAM_SIZE + 1;
  // Counter spans 0..2N during LOAD, so one bit wider than the address
  localparam int c_CNT_W  = L_RAM_SIZE + 2;

  localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(2 * VECTOR_SIZE);
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(2 * VECTOR_SIZE - 1);
  localparam logic [c_CNT_W-1:0] c_CALC_LAST = c_CNT_W'(VECTOR_SIZE - 1);
  localparam logic [c_CNT_W-1:0] c_DONE_LAST = c_CNT_W'(DONE_CYCLES);

  pe_state_t            r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]    r_a_buf [VECTOR_SIZE];
  logic [DATA_W-1:0]    r_b_buf [VECTOR_SIZE];

  logic [c_ADDR_W-1:0]  w_word;
  logic                 w_mac_clr;
  logic                 w_mac_en;
  logic [DATA_W-1:0]    w_mac_a;
  logic [DATA_W-1:0]    w_mac_b;
  logic [c_RES_W-1:0]   w_acc;

  // RAM data arriving in LOAD cycle k belongs to word k-1
  assign w_word    = r_cnt[c_ADDR_W-1:0] - c_ADDR_W'(1);

  assign w_mac_clr = (r_state == ST_IDLE) && start;
  assign w_mac_en  = (r_state == ST_CALC);
  assign w_mac_a   = r_a_buf[r_cnt[L_RAM_SIZE-1:0]];
  assign w_mac_b   = r_b_buf[r_cnt[L_RAM_SIZE-1:0]];

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (c_RES_W)
  ) u_mac (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_clr   (w_mac_clr),
    .i_en    (w_mac_en),
    .i_a     (w_mac_a),
    .i_b     (w_mac_b),
    .o_acc   (w_acc)
  );

  // Controller FSM with registered address, done and result outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      rdaddr  <= '0;
      done    <= 1'b0;
      result  <= '0;
      for (int j = 0; j < VECTOR_SIZE; j++) begin
        r_a_buf[j] <= '0;
        r_b_buf[j] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
          end
        end

        ST_LOAD: begin
          if (r_cnt != '0) begin
            if (w_word[L_RAM_SIZE]) begin
              r_b_buf[w_word[L_RAM_SIZE-1:0]] <= rddata;
            end else begin
              r_a_buf[w_word[L_RAM_SIZE-1:0]] <= rddata;
            end
          end
          if (r_cnt == c_LOAD_LAST) begin
            r_state <= ST_CALC;
            r_cnt   <= '0;
            rdaddr  <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            // Last address is held through the final capture cycle
            if (r_cnt < c_ADDR_LAST) begin
              rdaddr <= rdaddr + c_ADDR_W'(1);
            end
          end
        end

        ST_CALC: begin
          if (r_cnt == c_CALC_LAST) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        ST_DONE: begin
          // First DONE cycle: the accumulator has settled, publish it
          if (r_cnt == '0) begin
            result <= w_acc;
            done   <= 1'b1;
          end
          if (r_cnt == c_DONE_LAST) begin
            done    <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_controller
// Brief    : Self-checking bench for pe_controller. A run-level model derives
//            the expected address, done and result for every cycle from the
//            run's start time and the memory contents.
// Config   : PE_CON_SIGNED_EN - selects signed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_controller;

  localparam int N       = 8;
  localparam int LAT     = 3 * N + 2;  // start edge to first done cycle
  localparam int RUN_LEN = LAT + 5;    // phase of the first cycle back in IDLE

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  rddata;
  logic [3:0]  rdaddr;
  logic        done;
  logic [18:0] result;

  logic [7:0]  mem [0:2*N-1];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          phase = -1;
  int          run_sum = 0;
  logic [18:0] exp_result = '0;

  pe_controller dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (start),
    .rddata  (rddata),
    .rdaddr  (rdaddr),
    .done    (done),
    .result  (result)
  );

  always #5 aclk = ~aclk;

  // Synchronous RAM with one cycle of read latency
  always @(posedge aclk) rddata <= mem[rdaddr];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int elem(input logic [7:0] v);
`ifdef PE_CON_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  function automatic int dot();
    int s = 0;
    for (int i = 0; i < N; i++) s += elem(mem[i]) * elem(mem[N + i]);
    return s;
  endfunction

  function automatic int exp_addr(input int p);
    if (p >= 0 && p < 2 * N) return p;
    if (p == 2 * N) return 2 * N - 1;
    return 0;
  endfunction

  // Run-level model: phase counts edges since the accepted start
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      phase      = -1;
      exp_result = '0;
    end else if ((phase < 0 || phase >= RUN_LEN) && start) begin
      phase   = 0;
      run_sum = dot();
    end else if (phase >= 0 && phase < RUN_LEN) begin
      phase++;
      if (phase == LAT) exp_result = 19'(run_sum);
    end else begin
      phase = -1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge aclk) begin
    if (cyc > 0) begin
      check("rdaddr", 32'(rdaddr), 32'(exp_addr(phase)));
      check("done", 32'(done), (phase >= LAT && phase < LAT + 5) ? 32'd1 : 32'd0);
      check("result", 32'(result), 32'(exp_result));
    end
  end

  task automatic load_pattern(input int p);
    for (int i = 0; i < N; i++) begin
      case (p)
        1:       begin mem[i] = 8'(i + 1); mem[N + i] = 8'd1;  end
        2:       begin mem[i] = 8'hFF;     mem[N + i] = 8'hFF; end
        3:       begin mem[i] = 8'(i);     mem[N + i] = 8'd2;  end
        4:       begin mem[i] = 8'd3;      mem[N + i] = 8'(i); end
        default: begin mem[i] = 8'd10;     mem[N + i] = 8'(i + 1); end
      endcase
    end
  endtask

  // One run: start (unless already held), wait for done, check latency,
  // result and done length. noise pulses start mid-run; hold re-arms start
  // and swaps memory during DONE for a back-to-back run.
  task automatic run(input string nm, input int lit, input bit noise,
                     input bit hold, input int next_pat);
    int t0, t1, ndone;
    bit seen;
    if (!start) begin
      @(posedge aclk); #2;
      start = 1'b1;
    end
    @(posedge aclk);
    @(negedge aclk);
    t0    = cyc;
    start = 1'b0;
    seen  = 1'b0;
    t1    = 0;
    for (int w = 1; w <= 60 && !seen; w++) begin
      @(negedge aclk);
      start = noise && (w == 5 || w == 20);
      if (done) begin
        seen = 1'b1;
        t1   = cyc;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({nm, "_latency"}, t1 - t0, LAT);
      check({nm, "_result"}, 32'(result), 32'(lit));
      check({nm, "_model"}, 32'(exp_result), 32'(lit));
      if (hold) begin
        load_pattern(next_pat);
        start = 1'b1;
      end
      ndone = 1;
      for (int w = 0; w < 10 && done; w++) begin
        @(negedge aclk);
        if (noise) start = (w == 1);
        if (done) ndone++;
      end
      check({nm, "_done_len"}, ndone, 5);
    end
  endtask

  initial begin
    load_pattern(1);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset_rdaddr", 32'(rdaddr), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    @(posedge aclk); #2;
    aresetn = 1'b1;

    // 1: ascending A, unit B
    run("t1", 36, 1'b0, 1'b0, 0);

    // 2: all ones-byte operands
    load_pattern(2);
`ifdef PE_CON_SIGNED_EN
    run("t2", 8, 1'b0, 1'b0, 0);
`else
    run("t2", 520200, 1'b0, 1'b0, 0);
`endif

    // 3: A[i]=i, B=2
    load_pattern(3);
    run("t3", 56, 1'b0, 1'b0, 0);

    // 4: reset in the middle of CALC, then a clean run
    load_pattern(1);
    @(posedge aclk); #2;
    start = 1'b1;
    @(posedge aclk); #2;
    start = 1'b0;
    repeat (19) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    @(negedge aclk);
    check("abort_done", 32'(done), 32'd0);
    check("abort_rdaddr", 32'(rdaddr), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    load_pattern(4);
    run("t4", 84, 1'b0, 1'b0, 0);

    // 5: start pulses in LOAD, CALC and DONE are ignored
    load_pattern(5);
    run("t5", 360, 1'b1, 1'b0, 0);

    // 6: back-to-back with start held across DONE->IDLE and new memory
    load_pattern(3);
    run("t6a", 56, 1'b0, 1'b1, 1);
    run("t6b", 36, 1'b0, 1'b0, 0);

    repeat (3) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
